// File: rtl/sokoban_gfx_pkg.sv
// Shared constants and type definitions for the Sokoban tile renderer.
package sokoban_gfx_pkg;

  localparam int unsigned TILE_COLS     = 20;
  localparam int unsigned TILE_ROWS     = 15;
  localparam int unsigned TILE_PX       = 8;
  localparam int unsigned SPRITE_CYCLES = 66;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } render_state_t;

  typedef enum logic {
    MODE_FULL,
    MODE_SINGLE
  } render_mode_t;

  typedef enum logic [2:0] {
    TILE_FLOOR          = 3'd0,
    TILE_WALL           = 3'd1,
    TILE_BOX            = 3'd2,
    TILE_GOAL           = 3'd3,
    TILE_PLAYER         = 3'd4,
    TILE_BOX_ON_GOAL    = 3'd5,
    TILE_PLAYER_ON_GOAL = 3'd6,
    TILE_BLANK          = 3'd7
  } tile_code_t;

endpackage

// File: rtl/sprite_pacer.sv
// Load/count-down timer: expire pulses on the CYCLES-th cycle after load.
module sprite_pacer import sokoban_gfx_pkg::*; #(
  parameter int unsigned CYCLES = SPRITE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expire
);

  localparam int unsigned W = $clog2(CYCLES + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= W'(CYCLES);
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = (count == W'(1));

endmodule

// File: rtl/board_render_sequencer.sv
// Walks the tile board (or one tile), fetching each tile code and issuing a paced sprite draw.
module board_render_sequencer import sokoban_gfx_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_full,
  input  logic       req_tile,
  input  logic [4:0] req_col,
  input  logic [3:0] req_row,
  output logic [8:0] tile_addr,
  input  logic [2:0] tile_data,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] sprite_id,
  output logic       begin_draw,
  output logic       busy,
  output logic       done
);

  render_state_t state, state_nxt;
  render_mode_t  mode;
  logic [4:0]    col;
  logic [3:0]    row;
  logic          req_ok;
  logic          last_tile;
  logic          pacer_load;
  logic          wait_expire;

  assign req_ok    = req_tile && (32'(req_col) < TILE_COLS) && (32'(req_row) < TILE_ROWS);
  assign last_tile = (mode == MODE_SINGLE) ||
                     ((col == 5'(TILE_COLS - 1)) && (row == 4'(TILE_ROWS - 1)));

  // col/row only move at the end of WAIT, so the address is stable across FETCH and LATCH
  assign tile_addr = 9'(row) * 9'(TILE_COLS) + 9'(col);

  sprite_pacer #(.CYCLES(SPRITE_CYCLES)) u_pacer (
    .clk    (clk),
    .reset  (reset),
    .load   (pacer_load),
    .expire (wait_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pacer_load = 1'b0;
    begin_draw = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_full || req_ok) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        busy      = 1'b1;
        state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        busy      = 1'b1;
        state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        busy       = 1'b1;
        begin_draw = 1'b1;
        pacer_load = 1'b1;
        state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (wait_expire) state_nxt = last_tile ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode      <= MODE_FULL;
      col       <= '0;
      row       <= '0;
      x_out     <= '0;
      y_out     <= '0;
      sprite_id <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_full) begin
            mode <= MODE_FULL;
            col  <= '0;
            row  <= '0;
          end else if (req_ok) begin
            mode <= MODE_SINGLE;
            col  <= req_col;
            row  <= req_row;
          end
        end
        ST_LATCH: begin
          sprite_id <= tile_data;
          x_out     <= {col, 3'b000};
          y_out     <= {row, 3'b000};
        end
        ST_WAIT: begin
          if (wait_expire && !last_tile) begin
            if (col == 5'(TILE_COLS - 1)) begin
              col <= '0;
              row <= row + 4'd1;
            end else begin
              col <= col + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_render_sequencer.sv
// Self-checking bench for board_render_sequencer against a cycle-timeline model of tile draws.
module tb_board_render_sequencer;

  localparam int COLS   = 20;
  localparam int ROWS   = 15;
  localparam int PERIOD = 69;

  logic       clk;
  logic       reset;
  logic       start_full;
  logic       req_tile;
  logic [4:0] req_col;
  logic [3:0] req_row;
  logic [8:0] tile_addr;
  logic [2:0] tile_data;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] sprite_id;
  logic       begin_draw;
  logic       busy;
  logic       done;

  board_render_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start_full (start_full),
    .req_tile   (req_tile),
    .req_col    (req_col),
    .req_row    (req_row),
    .tile_addr  (tile_addr),
    .tile_data  (tile_data),
    .x_out      (x_out),
    .y_out      (y_out),
    .sprite_id  (sprite_id),
    .begin_draw (begin_draw),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] ram [0:511];
  always @(posedge clk) tile_data <= ram[tile_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: an accepted request owns the timeline from its first FETCH cycle t0
  bit m_active = 0;
  bit m_single = 0;
  int m_t0 = 0;
  int m_n = 0;
  int m_col = 0;
  int m_row = 0;

  function automatic bit model_idle();
    return !m_active || (cyc > m_t0 + PERIOD * m_n);
  endfunction

  task automatic model_req(input bit sf, input bit rt, input int c, input int r);
    if (!model_idle()) return;
    if (sf) begin
      m_active = 1; m_single = 0; m_t0 = cyc + 1; m_n = COLS * ROWS;
    end else if (rt && c < COLS && r < ROWS) begin
      m_active = 1; m_single = 1; m_t0 = cyc + 1; m_n = 1; m_col = c; m_row = r;
    end
  endtask

  typedef struct { int c; int x; int y; int id; } pulse_t;
  pulse_t pulse_q[$];
  int     done_q[$];
  int     fetch_q[$];
  int     fetch_addr_q[$];
  logic   busy_prev = 1'b0;

  int rel, k, ph, ecol, erow;
  bit eb, ed;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_begin_draw", int'(begin_draw), 0);
      chk("rst_tile_addr", int'(tile_addr), 0);
      chk("rst_x", int'(x_out), 0);
      chk("rst_y", int'(y_out), 0);
      chk("rst_id", int'(sprite_id), 0);
      busy_prev = 1'b0;
    end else begin
      rel = cyc - m_t0;
      eb  = m_active && rel >= 0 && rel < PERIOD * m_n;
      ed  = m_active && rel == PERIOD * m_n;
      k   = (rel >= 0) ? rel / PERIOD : 0;
      ph  = (rel >= 0) ? rel % PERIOD : 0;
      ecol = m_single ? m_col : k % COLS;
      erow = m_single ? m_row : k / COLS;
      chk("busy", int'(busy), int'(eb));
      chk("done", int'(done), int'(ed));
      chk("begin_draw", int'(begin_draw), int'(eb && ph == 2));
      if (eb && ph <= 1) chk("tile_addr", int'(tile_addr), erow * COLS + ecol);
      if (eb && ph >= 2) begin
        chk("x_out", int'(x_out), ecol * 8);
        chk("y_out", int'(y_out), erow * 8);
        chk("sprite_id", int'(sprite_id), int'(ram[erow * COLS + ecol]));
      end
      if (begin_draw) pulse_q.push_back('{cyc, int'(x_out), int'(y_out), int'(sprite_id)});
      if (done) done_q.push_back(cyc);
      if (busy && !busy_prev) begin
        fetch_q.push_back(cyc);
        fetch_addr_q.push_back(int'(tile_addr));
      end
      busy_prev = busy;
    end
  end

  task automatic clear_logs();
    pulse_q.delete();
    done_q.delete();
    fetch_q.delete();
    fetch_addr_q.delete();
  endtask

  task automatic send(input bit sf, input bit rt, input int c, input int r);
    @(negedge clk);
    start_full = sf;
    req_tile   = rt;
    req_col    = 5'(c);
    req_row    = 4'(r);
    model_req(sf, rt, c, r);
    @(negedge clk);
    start_full = 1'b0;
    req_tile   = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk(name, int'(i < limit), 1);
    @(negedge clk);
  endtask

  initial begin
    int bad;
    int i;
    start_full = 1'b0;
    req_tile   = 1'b0;
    req_col    = '0;
    req_row    = '0;
    for (int a = 0; a < 512; a++) ram[a] = 3'(a % 8);
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single tile at (3,2)
    ram[43] = 3'd2;
    clear_logs();
    send(0, 1, 3, 2);
    wait_done(200, "single_timeout");
    chk("single_pulses", pulse_q.size(), 1);
    if (pulse_q.size() >= 1) begin
      chk("single_x", pulse_q[0].x, 24);
      chk("single_y", pulse_q[0].y, 16);
      chk("single_id", pulse_q[0].id, 2);
    end
    chk("single_fetches", fetch_q.size(), 1);
    chk("single_dones", done_q.size(), 1);
    if (fetch_q.size() >= 1 && done_q.size() >= 1) begin
      chk("single_addr", fetch_addr_q[0], 43);
      chk("single_latency", done_q[0] - fetch_q[0], 69);
    end
    ram[43] = 3'd3;

    // out-of-range requests are ignored
    clear_logs();
    send(0, 1, 20, 0);
    send(0, 1, 0, 15);
    send(0, 1, 31, 14);
    repeat (80) @(negedge clk);
    chk("oor_pulses", pulse_q.size(), 0);
    chk("oor_dones", done_q.size(), 0);
    chk("oor_busy", fetch_q.size(), 0);

    // simultaneous start_full + req_tile, with requests injected while busy
    clear_logs();
    send(1, 1, 5, 5);
    repeat ($urandom_range(50, 400)) @(negedge clk);
    send(1, 0, 0, 0);
    repeat ($urandom_range(100, 3000)) @(negedge clk);
    send(0, 1, 1, 1);
    repeat ($urandom_range(10, 60)) @(negedge clk);
    send(1, 1, 2, 2);
    wait_done(21000, "full_timeout");
    chk("full_pulses", pulse_q.size(), 300);
    chk("full_dones", done_q.size(), 1);
    bad = 0;
    for (int p = 1; p < pulse_q.size(); p++)
      if (pulse_q[p].c - pulse_q[p-1].c != 69) bad++;
    chk("full_spacing", bad, 0);
    if (pulse_q.size() == 300) begin
      chk("full_first_x", pulse_q[0].x, 0);
      chk("full_first_y", pulse_q[0].y, 0);
      chk("full_21_x", pulse_q[20].x, 0);
      chk("full_21_y", pulse_q[20].y, 8);
      chk("full_21_id", pulse_q[20].id, 4);
      chk("full_last_x", pulse_q[299].x, 152);
      chk("full_last_y", pulse_q[299].y, 112);
      chk("full_last_id", pulse_q[299].id, 3);
    end
    if (fetch_q.size() >= 1 && done_q.size() >= 1)
      chk("full_duration", done_q[0] - fetch_q[0], 20700);

    // asynchronous reset during the WAIT of tile 5, then restart
    clear_logs();
    send(1, 0, 0, 0);
    for (i = 0; i < 600; i++) begin
      @(negedge clk);
      if (pulse_q.size() >= 6) break;
    end
    chk("tile5_reached", int'(i < 600), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    m_active = 0;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_tile_addr", int'(tile_addr), 0);
    chk("async_x", int'(x_out), 0);
    chk("async_y", int'(y_out), 0);
    chk("async_id", int'(sprite_id), 0);
    chk("async_done", int'(done), 0);
    chk("async_begin_draw", int'(begin_draw), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    send(1, 0, 0, 0);
    wait_done(21000, "restart_timeout");
    chk("restart_pulses", pulse_q.size(), 300);
    if (pulse_q.size() >= 1) begin
      chk("restart_first_x", pulse_q[0].x, 0);
      chk("restart_first_y", pulse_q[0].y, 0);
    end

    // random single-tile traffic with random board contents
    for (int a = 0; a < 512; a++) ram[a] = 3'($urandom_range(0, 7));
    clear_logs();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      start_full = 1'b0;
      req_tile   = ($urandom_range(0, 19) == 0);
      req_col    = 5'($urandom_range(0, 23));
      req_row    = 4'($urandom_range(0, 15));
      model_req(1'b0, req_tile, int'(req_col), int'(req_row));
    end
    @(negedge clk);
    req_tile = 1'b0;
    repeat (80) @(negedge clk);
    chk("random_activity", int'(pulse_q.size() > 5), 1);
    chk("random_pulse_done_match", pulse_q.size(), done_q.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/board_render_sequencer.md
Name: board_render_sequencer

Overview:
- Upstream stage of the 8x8 sprite drawer. Walks the 20x15 Sokoban tile board (160x120 px screen).
- For each tile: reads its tile code from the board RAM, then issues one sprite draw (anchor x/y, sprite id, begin_draw pulse) to the sprite drawer.
- Supports a full-board redraw and a single-tile redraw (used after a player move).
- Paces issues by a fixed cycle budget, because the sprite drawer has no done/ready output.

Parameters:
- TILE_COLS, 20, tiles per row
- TILE_ROWS, 15, tile rows
- SPRITE_CYCLES, 66, minimum wait from a begin_draw pulse to the next one (drawer: 1 load-wait + 64 draw + 1 return cycle)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start_full  in  1  sampled in IDLE only; request a redraw of all tiles
- req_tile  in  1  sampled in IDLE only; request a redraw of one tile
- req_col  in  5  column of the single-tile request
- req_row  in  4  row of the single-tile request
- tile_addr  out  9  board RAM read address, row*TILE_COLS+col
- tile_data  in  3  board RAM read data; registered, valid 1 cycle after tile_addr
- x_out  out  8  sprite anchor x = col*8
- y_out  out  7  sprite anchor y = row*8
- sprite_id  out  3  sprite index = tile_data as latched
- begin_draw  out  1  1-cycle go pulse to the sprite drawer
- busy  out  1  high from the cycle after an accepted request until done
- done  out  1  1-cycle pulse when the request completes

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted, all outputs are 0, state is IDLE, and the col/row/wait counters are 0.
- A sprite draw already in flight downstream finishes on its own; no recovery is attempted.
- States: IDLE, FETCH, LATCH, ISSUE, WAIT, DONE.
- IDLE:
  - start_full=1: col=row=0, mode=FULL, go to FETCH.
  - Else req_tile=1 with req_col<TILE_COLS and req_row<TILE_ROWS: col/row latched, mode=SINGLE, go to FETCH.
  - Out-of-range req_tile: ignored (no busy, no done).
  - start_full and req_tile in the same cycle: full wins; the tile request is dropped.
- FETCH: tile_addr driven from col/row (held stable through LATCH).
- LATCH: tile_data captured into sprite_id. x_out={col,3'b000} and y_out={row,3'b000} registered.
- ISSUE: begin_draw=1 for exactly this cycle. x_out, y_out and sprite_id are stable from this cycle until the next LATCH.
- WAIT:
  - Counter runs SPRITE_CYCLES cycles.
  - On the last WAIT cycle in SINGLE mode, or in FULL mode at col=TILE_COLS-1, row=TILE_ROWS-1: go to DONE.
  - Otherwise advance (col+1; at TILE_COLS-1, col wraps to 0 and row+1) and go to FETCH.
- DONE: done=1 for one cycle, busy=0 in the same cycle, return to IDLE.
- Per-tile period is SPRITE_CYCLES+3 cycles. ISSUE-to-ISSUE spacing is SPRITE_CYCLES+3, which is at least 66.
- Full redraw: 300*69 = 20700 cycles from the first FETCH to DONE.
- start_full and req_tile are ignored while busy (no queueing).
- Arithmetic:
  - tile_addr = row*20+col, computed in 9 bits; maximum value 299.
  - x_out maximum 152, y_out maximum 112; no overflow.

Decomposition:
- Package sokoban_gfx_pkg:
  - TILE_COLS, TILE_ROWS, TILE_PX=8, state encoding.
  - Tile codes: FLOOR=0, WALL=1, BOX=2, GOAL=3, PLAYER=4, BOX_ON_GOAL=5, PLAYER_ON_GOAL=6, BLANK=7.
- One sub-module, sprite_pacer: a load/count-down counter giving a 1-cycle expire at SPRITE_CYCLES.
- Address and coordinate logic stay in the top level.

Test Plan:
- Single tile: req_tile, col=3, row=2, RAM[43]=2 -> tile_addr=43; begin_draw once with x_out=24, y_out=16, sprite_id=2; done 69 cycles after the first FETCH; busy high throughout.
- Full redraw with RAM[i]=i%8 -> 300 begin_draw pulses, each spaced exactly 69 cycles; 21st pulse has x=0, y=8, id=4; last pulse has x=152, y=112, id=299%8=3; exactly one done.
- Simultaneous start_full and req_tile in IDLE -> full sequence only; first issue at x=0, y=0.
- req_tile with col=20 or row=15 -> no busy, no begin_draw, no done; FSM stays in IDLE.
- start_full while busy, and req_tile mid-wait -> ignored; pulse count and done timing unchanged.
- Assert reset during the WAIT of tile 5 -> all outputs 0 immediately, asynchronously. A subsequent start_full restarts at tile 0.
